// File: rtl/jk_cmd_sequencer.sv
// Command sequencer feeding a JK flip-flop: queues {op, count} commands in a
// small FIFO and replays each op on registered j/k for count cycles.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_count,
    output logic                     j,
    output logic                     k,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   remaining_n;
    logic               j_n;
    logic               k_n;
    logic               done_n;

    logic [CNT_W+1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               push;
    logic               pop;
    logic               empty;
    logic [1:0]         head_op;
    logic [CNT_W-1:0]   head_cnt;
    logic [CNT_W-1:0]   head_eff;

    assign cmd_ready = !rst && !flush && (level != LVL_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign empty     = (level == '0);
    assign busy      = (state == RUN) || !empty;

    assign head_op   = mem[rd_ptr][CNT_W+1:CNT_W];
    assign head_cnt  = mem[rd_ptr][CNT_W-1:0];
    assign head_eff  = (head_cnt == '0) ? CNT_W'(1) : head_cnt;

    // j/k double as the active-op register while in RUN.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        j_n         = 1'b0;
        k_n         = 1'b0;
        done_n      = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    state_n     = RUN;
                    remaining_n = head_eff;
                    {j_n, k_n}  = head_op;
                    done_n      = (head_eff == CNT_W'(1));
                end
            end
            RUN: begin
                if (remaining == CNT_W'(1)) begin
                    if (!empty) begin
                        pop         = 1'b1;
                        remaining_n = head_eff;
                        {j_n, k_n}  = head_op;
                        done_n      = (head_eff == CNT_W'(1));
                    end else begin
                        state_n     = IDLE;
                        remaining_n = '0;
                    end
                end else begin
                    remaining_n = remaining - CNT_W'(1);
                    j_n         = j;
                    k_n         = k;
                    done_n      = (remaining == CNT_W'(2));
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= IDLE;
            remaining <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
            done      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            j         <= j_n;
            k         <= k_n;
            done      <= done_n;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_op, cmd_count};
    end

endmodule
